bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-requester arbiter sharing the single port of the PL block RAM between the PS-side AXI BRAM controller path (requester 0, GP0 window at 0xA000_0000) and a PL datapath engine (requester 1). Requesters issue single-word read or write transactions; the block grants them with a round-robin policy and drives the BRAM port with registered signals. It returns read data to the originating requester in order, and supports a bounded lock so requester 0 can perform atomic read-modify-write sequences.

## Interface
Parameters:
- ADDR_W, 13, word address width (32 KB window)
- DATA_W, 32, data width; byte strobes are DATA_W/8 wide
- RD_LAT, 1, BRAM read latency in cycles from registered enable; legal values 1 or 2
- LOCK_MAX, 16, maximum consecutive cycles requester 0 may hold a lock

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- m0_req / m1_req  in  1  transaction request; held with payload stable until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_W  word address
- m0_wdata / m1_wdata  in  DATA_W  write data
- m0_wstrb / m1_wstrb  in  DATA_W/8  byte enables for writes
- m0_lock  in  1  sampled with an accepted m0 transaction; requests lock
- m0_gnt / m1_gnt  out  1  acceptance; transaction accepted in cycle where req & gnt
- m0_rvalid / m1_rvalid  out  1  one-cycle read response pulse
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with rvalid
- bram_en  out  1  port enable
- bram_we  out  DATA_W/8  byte write enables (0 for reads)
- bram_addr  out  ADDR_W  port address
- bram_din  out  DATA_W  port write data
- bram_dout  in  DATA_W  port read data

## Operation
- Arbitration is combinational from req inputs and registered state; at most one gnt high per cycle; both gnt forced 0 while ARESETn low.
- Round-robin: register `prio` (reset = 0, meaning m0 first). If only one requester active, it is granted. If both are active, `prio` wins. After any grant, `prio` points at the other requester.
- States: IDLE, LOCKED. Reset -> IDLE.
- IDLE -> LOCKED when an m0 transaction is accepted with m0_lock = 1; lock counter loads LOCK_MAX-1.
- In LOCKED: m1 is never granted; m0 is granted whenever m0_req is high. The counter decrements every cycle.
- LOCKED -> IDLE when an m0 transaction is accepted with m0_lock = 0, or when the counter reaches 0 (timeout), whichever comes first. On exit, `prio` = 1.
- An m0 accept with lock = 1 while already LOCKED does not reload the counter.
- If m0 drops req while LOCKED, m1 stays blocked until timeout.
- Accepted transaction drives bram_en/we/addr/din from registers the next cycle. Idle cycles: bram_en = 0 and bram_we = 0; addr and din hold their last value.
- Read responses are tracked by a RD_LAT+1 deep valid/ID shift pipeline. No FIFO, no backpressure. Responses return in issue order. Back-to-back reads sustain one per cycle.
- Writes complete at acceptance; they produce no response.
- rdata is registered from bram_dout and routed to the requester by ID; the other requester's rdata holds its previous value.

## Timing
- Reset values: gnt 0, rvalid 0, rdata 0, bram_en 0, bram_we 0, bram_addr 0, bram_din 0, prio 0, state IDLE, counter 0, pipeline empty.
- Accept in cycle N -> bram port active in N+1.
- Read accepted in N -> mX_rvalid high in N+1+RD_LAT+1 (N+3 for RD_LAT = 1).
- Write accepted in N followed by a read of the same address accepted in N+1 returns the new data; BRAM is read-first/write-first agnostic because the accesses are in separate cycles.
- Reset asserted mid-operation clears the pipeline immediately. Reads in flight produce no rvalid after reset release.
- Throughput: 1 transaction per cycle aggregate.

## Test plan
- m0 writes 0xDEADBEEF, wstrb 0xF to addr 0, then reads addr 0 -> m0_rvalid at accept+3 (RD_LAT = 1) with m0_rdata = 0xDEADBEEF; m1_rvalid stays 0.
- Both requesters continuously request reads from reset -> grants alternate m0, m1, m0, m1 each cycle; each rvalid is routed to the correct requester with that requester's address data.
- m0 write to addr 4 with wstrb 0x3, data 0x1234_5678, over prior 0xFFFF_FFFF -> readback 0xFFFF_5678.
- m0 accepts with lock = 1, m1 requesting throughout, m0 idle afterwards -> m1_gnt stays 0 for exactly LOCK_MAX = 16 cycles, then m1 is granted next. Repeat with m0 accepting with lock = 0 after 3 cycles -> m1 is granted in the following cycle.
- Back-to-back m1 reads of addrs 0..7 -> eight consecutive m1_rvalid pulses, in order, with no gaps; repeat with RD_LAT = 2 to confirm latency +1.
- ARESETn pulsed low one cycle after a read accept -> all outputs return to reset values asynchronously; no rvalid after release; the next simultaneous request grants m0.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin arbiter sharing one BRAM port between two requesters,
// with a bounded lock that lets requester 0 run atomic read-modify-write sequences.
module bram_port_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int LOCK_MAX = 16
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_lock,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m0_gnt,
    output logic                m1_gnt,
    output logic                m0_rvalid,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                bram_en,
    output logic [DATA_W/8-1:0] bram_we,
    output logic [ADDR_W-1:0]   bram_addr,
    output logic [DATA_W-1:0]   bram_din,
    input  logic [DATA_W-1:0]   bram_dout
);
    localparam int SW = DATA_W / 8;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {IDLE, LOCKED} state_t;
    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt;
    logic              r_prio;
    logic [RD_LAT:0]   r_pv, r_pid;
    logic              w_locked, w_gnt0, w_gnt1, w_acc, w_we, w_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [SW-1:0]     w_wstrb;

    assign w_locked = r_state == LOCKED;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next == LOCKED) ? (w_locked ? r_cnt - 1'b1 : CW'(LOCK_MAX - 1)) : '0;
            r_prio  <= (w_gnt0 || (w_locked && w_next == IDLE)) ? 1'b1 : (w_gnt1 ? 1'b0 : r_prio);
        end
    end

    // the counter only reaches zero in LOCKED on the final locked cycle
    always_comb
        w_next = w_locked ? ((((w_gnt0 && !m0_lock) || r_cnt == '0)) ? IDLE : LOCKED)
                          : ((w_gnt0 && m0_lock) ? LOCKED : IDLE);

    always_comb begin
        w_gnt0 = ARESETn && m0_req && (w_locked || !m1_req || !r_prio);
        w_gnt1 = ARESETn && m1_req && !w_locked && (!m0_req || r_prio);
    end

    assign m0_gnt  = w_gnt0;
    assign m1_gnt  = w_gnt1;
    assign w_acc   = w_gnt0 || w_gnt1;
    assign w_we    = w_gnt1 ? m1_we    : m0_we;
    assign w_addr  = w_gnt1 ? m1_addr  : m0_addr;
    assign w_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    assign w_wstrb = w_gnt1 ? m1_wstrb : m0_wstrb;
    assign w_rd    = w_acc && !w_we;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bram_en   <= 1'b0;
            bram_we   <= '0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_en <= w_acc;
            bram_we <= (w_acc && w_we) ? w_wstrb : '0;
            if (w_acc) begin
                bram_addr <= w_addr;
                bram_din  <= w_wdata;
            end
        end
    end

    // stage RD_LAT lines up with bram_dout for the read issued RD_LAT+1 cycles earlier
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_pv      <= '0;
            r_pid     <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            r_pv      <= {r_pv[RD_LAT-1:0], w_rd};
            r_pid     <= {r_pid[RD_LAT-1:0], w_gnt1};
            m0_rvalid <= r_pv[RD_LAT] && !r_pid[RD_LAT];
            m1_rvalid <= r_pv[RD_LAT] && r_pid[RD_LAT];
            if (r_pv[RD_LAT] && !r_pid[RD_LAT])
                m0_rdata <= bram_dout;
            if (r_pv[RD_LAT] && r_pid[RD_LAT])
                m1_rdata <= bram_dout;
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: randomized and directed checks of the BRAM port arbiter against
// a cycle-level reference model (round robin, lock window, shadow memory, response schedule).
module tb_bram_port_arbiter;
    localparam int LM = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we;
    logic [12:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [12:0] bram_addr;
    logic [31:0] bram_din, bram_dout;
    logic [31:0] mem [0:8191];

    logic        n1_req;
    logic [12:0] n1_addr;
    logic        u2_m0_gnt, u2_m1_gnt, u2_m0_rvalid, u2_m1_rvalid, u2_en;
    logic [31:0] u2_m0_rdata, u2_m1_rdata, u2_din, u2_dout, d2a;
    logic [3:0]  u2_we;
    logic [12:0] u2_addr;

    bram_port_arbiter #(.RD_LAT(1), .LOCK_MAX(LM)) u_dut (
        .ACLK(clk), .ARESETn(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_lock(m0_lock),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    bram_port_arbiter #(.RD_LAT(2), .LOCK_MAX(LM)) u_dut2 (
        .ACLK(clk), .ARESETn(rst_n),
        .m0_req(1'b0), .m0_we(1'b0), .m0_addr(13'd0), .m0_wdata(32'd0),
        .m0_wstrb(4'd0), .m0_lock(1'b0),
        .m1_req(n1_req), .m1_we(1'b0), .m1_addr(n1_addr), .m1_wdata(32'd0),
        .m1_wstrb(4'd0),
        .m0_gnt(u2_m0_gnt), .m1_gnt(u2_m1_gnt), .m0_rvalid(u2_m0_rvalid), .m1_rvalid(u2_m1_rvalid),
        .m0_rdata(u2_m0_rdata), .m1_rdata(u2_m1_rdata),
        .bram_en(u2_en), .bram_we(u2_we), .bram_addr(u2_addr), .bram_din(u2_din),
        .bram_dout(u2_dout)
    );

    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_din[8*b +: 8];
            bram_dout <= mem[bram_addr];
        end
    end

    function automatic logic [31:0] pat(input logic [12:0] a);
        return ({19'd0, a} * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    endfunction

    // two-cycle BRAM whose contents are a fixed function of the address
    always @(posedge clk) begin
        if (u2_en) d2a <= pat(u2_addr);
        u2_dout <= d2a;
    end

    int          checks, errors, cyc, m_prio, lock_left;
    logic [31:0] shadow [0:8191];
    logic        ev [16];
    logic        eid [16];
    logic [31:0] ed [16];
    logic [31:0] rd0_exp, rd1_exp, pe_din;
    logic        pe_en, dg0, dg1, dv1;
    logic [3:0]  pe_we;
    logic [12:0] pe_addr;

    task automatic mreset();
        m_prio = 0; lock_left = 0; rd0_exp = 0; rd1_exp = 0;
        pe_en = 0; pe_we = 0; pe_addr = 0; pe_din = 0;
        for (int i = 0; i < 16; i++) ev[i] = 0;
    endtask

    task automatic tick(output logic g0, output logic g1);
        logic locked, we;
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0] st;
        int s;
        #1;
        locked = lock_left > 0;
        g0 = m0_req && (locked || !m1_req || m_prio == 0);
        g1 = m1_req && !locked && (!m0_req || m_prio == 1);
        dg0 = m0_gnt; dg1 = m1_gnt; dv1 = m1_rvalid;
        checks++;
        if (m0_gnt !== g0 || m1_gnt !== g1) begin
            errors++;
            $display("FAIL gnt cyc=%0d got m0=%b m1=%b exp m0=%b m1=%b", cyc, m0_gnt, m1_gnt, g0, g1);
        end
        s = cyc % 16;
        checks++;
        if (m0_rvalid !== (ev[s] && !eid[s]) || m1_rvalid !== (ev[s] && eid[s])) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got m0=%b m1=%b exp valid=%b id=%b", cyc, m0_rvalid, m1_rvalid, ev[s], eid[s]);
        end
        if (ev[s]) begin
            if (eid[s]) rd1_exp = ed[s];
            else rd0_exp = ed[s];
        end
        ev[s] = 0;
        checks++;
        if (m0_rdata !== rd0_exp || m1_rdata !== rd1_exp) begin
            errors++;
            $display("FAIL rdata cyc=%0d got m0=%h m1=%h exp m0=%h m1=%h", cyc, m0_rdata, m1_rdata, rd0_exp, rd1_exp);
        end
        checks++;
        if (bram_en !== pe_en || bram_we !== pe_we || bram_addr !== pe_addr || bram_din !== pe_din) begin
            errors++;
            $display("FAIL port cyc=%0d got en=%b we=%h a=%h d=%h exp en=%b we=%h a=%h d=%h",
                     cyc, bram_en, bram_we, bram_addr, bram_din, pe_en, pe_we, pe_addr, pe_din);
        end
        pe_en = g0 || g1;
        pe_we = 0;
        if (g0 || g1) begin
            we = g1 ? m1_we : m0_we;
            a  = g1 ? m1_addr : m0_addr;
            d  = g1 ? m1_wdata : m0_wdata;
            st = g1 ? m1_wstrb : m0_wstrb;
            pe_addr = a; pe_din = d;
            if (we) begin
                pe_we = st;
                for (int b = 0; b < 4; b++)
                    if (st[b]) shadow[a][8*b +: 8] = d[8*b +: 8];
            end else begin
                ev[(cyc + 3) % 16] = 1; eid[(cyc + 3) % 16] = g1; ed[(cyc + 3) % 16] = shadow[a];
            end
        end
        if (g0) m_prio = 1;
        if (g1) m_prio = 0;
        if (locked) begin
            if (g0 && !m0_lock) lock_left = 0;
            else lock_left--;
            if (lock_left == 0) m_prio = 1;
        end else if (g0 && m0_lock) lock_left = LM;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) tick(g0, g1);
    endtask

    task automatic issue0(input logic we, input logic [12:0] a, input logic [31:0] d,
                          input logic [3:0] st, input logic lk);
        logic g0, g1;
        int n;
        n = 0;
        m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_wstrb = st; m0_lock = lk;
        do begin tick(g0, g1); n++; end while (!g0 && n < 40);
        m0_req = 0; m0_lock = 0;
        if (!g0) begin checks++; errors++; $display("FAIL issue0 timeout got no grant in %0d cycles", n); end
    endtask

    task automatic do_reset();
        m0_req = 0; m1_req = 0; m0_lock = 0;
        #1 rst_n = 0;
        #1 rst_n = 1;
        mreset();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en} !== 5'b0 || bram_we !== 4'b0 ||
            bram_addr !== 13'b0 || bram_din !== 32'b0 || m0_rdata !== 32'b0 || m1_rdata !== 32'b0) begin
            errors++;
            $display("FAIL reset_vals got gnt=%b%b rv=%b%b en=%b we=%h a=%h d=%h rd=%h/%h exp all zero",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en, bram_we, bram_addr, bram_din, m0_rdata, m1_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, bram_en, u2_m1_gnt, u2_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_held got gnt=%b%b en=%b u2gnt=%b u2en=%b exp 0", m0_gnt, m1_gnt, bram_en, u2_m1_gnt, u2_en);
        end
        @(negedge clk);
        rst_n = 1; m0_req = 0; m1_req = 0;
        mreset();
    endtask

    task automatic test_write_read();
        issue0(1, 13'd0, 32'hDEAD_BEEF, 4'hF, 0);
        issue0(0, 13'd0, 32'h0, 4'h0, 0);
        idle(4);
        checks++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL write_read got %h exp deadbeef", m0_rdata);
        end
    endtask

    task automatic test_strobe();
        issue0(1, 13'd4, 32'hFFFF_FFFF, 4'hF, 0);
        issue0(1, 13'd4, 32'h1234_5678, 4'h3, 0);
        issue0(0, 13'd4, 32'h0, 4'h0, 0);
        idle(4);
        checks++;
        if (m0_rdata !== 32'hFFFF_5678) begin
            errors++; $display("FAIL strobe got %h exp ffff5678", m0_rdata);
        end
    endtask

    task automatic test_alternate();
        logic g0, g1;
        logic [7:0] seq;
        seq = 0;
        m0_req = 1; m0_we = 0; m0_addr = 13'd0;
        m1_req = 1; m1_we = 0; m1_addr = 13'd4;
        for (int i = 0; i < 8; i++) begin tick(g0, g1); seq = {seq[6:0], dg0}; end
        m0_req = 0; m1_req = 0;
        idle(4);
        checks++;
        if (seq !== 8'b1010_1010) begin
            errors++; $display("FAIL alternate got m0 grant sequence %b exp 10101010", seq);
        end
    endtask

    task automatic test_lock_timeout();
        logic g0, g1;
        int cnt, n;
        cnt = 0; n = 0;
        m1_req = 1; m1_we = 0; m1_addr = 13'd0;
        issue0(0, 13'd4, 32'h0, 4'h0, 1);
        do begin tick(g0, g1); if (!dg1) cnt++; n++; end while (!dg1 && n < 40);
        checks++;
        if (cnt != LM) begin
            errors++; $display("FAIL lock_timeout got %0d blocked cycles exp %0d", cnt, LM);
        end
    endtask

    task automatic test_lock_release();
        logic g0, g1;
        int cnt;
        cnt = 0;
        issue0(0, 13'd4, 32'h0, 4'h0, 1);
        for (int i = 0; i < 2; i++) begin tick(g0, g1); if (!dg1) cnt++; end
        issue0(0, 13'd0, 32'h0, 4'h0, 0);
        tick(g0, g1);
        checks++;
        if (cnt != 2 || dg1 !== 1'b1) begin
            errors++; $display("FAIL lock_release got blocked=%0d gnt1=%b exp blocked=2 gnt1=1", cnt, dg1);
        end
        m1_req = 0;
        idle(4);
    endtask

    task automatic test_random();
        logic g0, g1;
        for (int a = 0; a < 64; a++) issue0(1, 13'(a), $urandom, 4'hF, 0);
        for (int k = 0; k < 400; k++) begin
            if (!m0_req && $urandom_range(0, 1) == 1) begin
                m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = 13'($urandom_range(0, 63));
                m0_wdata = $urandom; m0_wstrb = 4'($urandom); m0_lock = ($urandom_range(0, 7) == 0);
            end
            if (!m1_req && $urandom_range(0, 1) == 1) begin
                m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = 13'($urandom_range(0, 63));
                m1_wdata = $urandom; m1_wstrb = 4'($urandom);
            end
            tick(g0, g1);
            if (g0) m0_req = 0;
            if (g1) m1_req = 0;
        end
        m0_req = 0; m1_req = 0; m0_lock = 0;
        idle(LM + 6);
    endtask

    task automatic test_b2b_m1();
        logic g0, g1;
        int cnt;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            m1_req = k < 8; m1_we = 0; m1_addr = 13'(k);
            tick(g0, g1);
            if (dv1) cnt++;
        end
        m1_req = 0;
        idle(2);
        checks++;
        if (cnt != 8) begin
            errors++; $display("FAIL b2b got %0d rvalid pulses exp 8", cnt);
        end
    endtask

    task automatic test_rdlat2();
        for (int k = 0; k < 14; k++) begin
            n1_req = k < 8; n1_addr = 13'(k);
            #1;
            if (k < 8) begin
                checks++;
                if (u2_m1_gnt !== 1'b1) begin
                    errors++; $display("FAIL rdlat2_gnt k=%0d got %b exp 1", k, u2_m1_gnt);
                end
            end
            checks++;
            if (u2_m1_rvalid !== (k >= 4 && k < 12) || u2_m0_rvalid !== 1'b0) begin
                errors++; $display("FAIL rdlat2_rvalid k=%0d got m1=%b m0=%b exp m1=%b", k, u2_m1_rvalid, u2_m0_rvalid, (k >= 4 && k < 12));
            end
            if (k >= 4 && k < 12) begin
                checks++;
                if (u2_m1_rdata !== pat(13'(k - 4))) begin
                    errors++; $display("FAIL rdlat2_data k=%0d got %h exp %h", k, u2_m1_rdata, pat(13'(k - 4)));
                end
            end
            @(negedge clk);
        end
        n1_req = 0;
    endtask

    task automatic test_reset_midflight();
        logic g0, g1;
        issue0(0, 13'd4, 32'h0, 4'h0, 0);
        #2;
        rst_n = 0; m0_req = 1; m1_req = 1;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en} !== 5'b0 || bram_we !== 4'b0 ||
            bram_addr !== 13'b0 || bram_din !== 32'b0 || m0_rdata !== 32'b0 || m1_rdata !== 32'b0) begin
            errors++;
            $display("FAIL midflight_reset got gnt=%b%b rv=%b%b en=%b we=%h a=%h d=%h rd=%h/%h exp all zero",
                     m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, bram_en, bram_we, bram_addr, bram_din, m0_rdata, m1_rdata);
        end
        rst_n = 1; m0_req = 0; m1_req = 0;
        mreset();
        @(negedge clk);
        idle(5);
        m0_req = 1; m0_we = 0; m0_addr = 13'd0;
        m1_req = 1; m1_we = 0; m1_addr = 13'd4;
        tick(g0, g1);
        checks++;
        if (dg0 !== 1'b1 || dg1 !== 1'b0) begin
            errors++; $display("FAIL post_reset_grant got m0=%b m1=%b exp m0=1 m1=0", dg0, dg1);
        end
        m0_req = 0;
        tick(g0, g1);
        m1_req = 0;
        idle(4);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0;
        rst_n = 0;
        m0_req = 1; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0; m0_lock = 0;
        m1_req = 1; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        n1_req = 0; n1_addr = 0;
        mreset();
        test_reset();
        test_write_read();
        test_strobe();
        do_reset();
        test_alternate();
        test_lock_timeout();
        test_lock_release();
        test_random();
        test_b2b_m1();
        test_rdlat2();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
